// File: rtl/user_input_if.sv
// Level-in / pulse-out bundle for the edge-to-pulse converter.
interface user_input_if;
   logic in;
   logic out;

   modport master (output in, input out);
   modport slave  (input in, output out);
endinterface

// File: rtl/user_input.sv
// Edge-to-pulse converter: optional input synchronizer, two-state level tracker,
// registered one-cycle strobe per qualifying edge (rising, falling or both).
module user_input #(
   parameter int unsigned SYNC_STAGES = 0,
   parameter int unsigned EDGE        = 0
) (
   input logic         clk,
   input logic         reset,
   user_input_if.slave bus
);

   typedef enum logic {
      LOW  = 1'b0,
      HIGH = 1'b1
   } state_t;

   state_t state;
   logic   s;
   logic   prev_c;
   logic   hit_c;
   logic   out_q;

   // Synchronized sample; a zero-depth chain passes the input straight through.
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = bus.in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= bus.in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign prev_c = (state == HIGH);

   always_comb begin
      hit_c = 1'b0;
      case (EDGE)
         1:       hit_c = ~s & prev_c;
         2:       hit_c = s ^ prev_c;
         default: hit_c = s & ~prev_c;
      endcase
   end

   // Level tracker and output strobe; reset drops a pending pulse immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LOW;
         out_q <= 1'b0;
      end else begin
         case (state)
            LOW:  if (s)  state <= HIGH;
            HIGH: if (!s) state <= LOW;
         endcase
         out_q <= hit_c;
      end
   end

   assign bus.out = out_q;

endmodule

// File: tb/tb_user_input.sv
// Scoreboard bench: five converter configurations share one input; a sequence
// model of sampled input history predicts every output cycle.
module tb_user_input;

   localparam int S_TAB [5] = '{0, 2, 0, 0, 2};
   localparam int E_TAB [5] = '{0, 0, 1, 2, 2};

   logic       clk = 1'b0;
   logic       reset;
   logic       din;
   logic [4:0] dout;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [4:0] exp_q [$];
   logic       hist  [$];
   bit         sq_win = 1'b0;
   int         sq_cnt = 0;

   always #5 clk = ~clk;

   user_input_if b0 ();
   user_input_if b1 ();
   user_input_if b2 ();
   user_input_if b3 ();
   user_input_if b4 ();

   assign b0.in = din;
   assign b1.in = din;
   assign b2.in = din;
   assign b3.in = din;
   assign b4.in = din;
   assign dout = {b4.out, b3.out, b2.out, b1.out, b0.out};

   user_input #(.SYNC_STAGES(0), .EDGE(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
   user_input #(.SYNC_STAGES(2), .EDGE(0)) u1 (.clk(clk), .reset(reset), .bus(b1));
   user_input #(.SYNC_STAGES(0), .EDGE(1)) u2 (.clk(clk), .reset(reset), .bus(b2));
   user_input #(.SYNC_STAGES(0), .EDGE(2)) u3 (.clk(clk), .reset(reset), .bus(b3));
   user_input #(.SYNC_STAGES(2), .EDGE(2)) u4 (.clk(clk), .reset(reset), .bus(b4));

   // Input value seen at edge i since reset release; anything earlier reads as 0.
   function automatic logic hist_at(int i);
      if (i < 0) return 1'b0;
      return hist[i];
   endfunction

   function automatic logic [4:0] model_out();
      logic [4:0] r;
      logic       cur;
      logic       prv;
      int         n;
      n = hist.size() - 1;
      r = '0;
      for (int d = 0; d < 5; d++) begin
         cur = hist_at(n - S_TAB[d]);
         prv = hist_at(n - S_TAB[d] - 1);
         case (E_TAB[d])
            1:       r[d] = !cur && prv;
            2:       r[d] = cur != prv;
            default: r[d] = cur && !prv;
         endcase
      end
      return r;
   endfunction

   task automatic check(input string name, input int d, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %b expected %b at %0t", name, d, got, exp, $time);
      end
   endtask

   // One clock: drive input, let the edge happen, record expected outputs.
   task automatic tick(input logic v);
      din = v;
      @(posedge clk);
      #1;
      if (!reset) begin
         hist.delete();
         exp_q.push_back(5'b0);
      end else begin
         hist.push_back(v);
         exp_q.push_back(model_out());
      end
   endtask

   initial begin : monitor
      logic [4:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (!reset) e = 5'b0;
            for (int d = 0; d < 5; d++) check("scoreboard", d, dout[d], e[d]);
            if (sq_win && dout[0]) sq_cnt++;
         end
      end
   end

   initial begin : stim
      logic r;
      reset = 1'b0;
      din   = 1'b0;

      // Reset held with a toggling input, then released with input low.
      for (int i = 0; i < 6; i++) tick(1'($urandom_range(0, 1)));
      reset = 1'b1;
      repeat (5) tick(1'b0);

      // Single held press.
      repeat (20) tick(1'b1);
      repeat (10) tick(1'b0);

      // Square wave of period 8 for 10 periods.
      sq_win = 1'b1;
      for (int c = 0; c < 80; c++) tick(c[2]);
      @(negedge clk);
      #1;
      sq_win = 1'b0;
      n_tests++;
      if (sq_cnt != 10) begin
         n_fail++;
         $display("FAIL square_pulse_count: got %0d expected 10", sq_cnt);
      end

      // High for 5 cycles then low: falling and both-edge behaviour.
      repeat (5) tick(1'b1);
      repeat (8) tick(1'b0);

      // Asynchronous reset while a pulse is high.
      tick(1'b1);
      #1;
      check("pulse_before_reset", 0, dout[0], 1'b1);
      #1;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 5; d++) check("async_reset_clear", d, dout[d], 1'b0);
      tick(1'b1);
      tick(1'b1);
      reset = 1'b1;
      repeat (6) tick(1'b1);
      repeat (4) tick(1'b0);

      // Random runs and glitches, with one reset burst in the middle.
      r = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (i == 150) reset = 1'b0;
         if (i == 153) reset = 1'b1;
         if ($urandom_range(0, 2) == 0) r = ~r;
         tick(r);
      end
      repeat (4) tick(1'b0);
      @(negedge clk);
      #1;

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
